// File: rtl/fft_pkg.sv
// fft_pkg
// Shared definitions for the FFT band peak extractor:
//   - peak_state_t : peak extractor FSM states
//   - BAND_END     : last bin of each frequency band (inclusive)
//   - BAND_W       : width of a band index
//   - band_start() : first bin of a band
//   - band_of()    : band that owns a bin
package fft_pkg;

    localparam int MAX_BANDS = 6;
    localparam int BAND_W    = 3;

    localparam int BAND_END [MAX_BANDS] = '{9, 19, 39, 79, 159, 511};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_EMIT,
        ST_REARM
    } peak_state_t;

    function automatic int band_start(input int b);
        if (b == 0)
            return 0;
        else
            return BAND_END[b-1] + 1;
    endfunction

    // First band whose end is >= bin; walking downwards lets the lowest match win.
    function automatic logic [BAND_W-1:0] band_of(input int bin, input int nb);
        logic [BAND_W-1:0] r;
        r = BAND_W'(nb - 1);
        for (int b = MAX_BANDS - 1; b >= 0; b--)
            if (b < nb && bin <= BAND_END[b])
                r = BAND_W'(b);
        return r;
    endfunction

endpackage

// File: rtl/band_magnitude_sq.sv
// band_magnitude_sq
// Two-stage registered squared magnitude re^2 + im^2 with bin/band tags
// carried alongside the data.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid            sample valid
//   re, im              signed sample
//   in_bin, in_band     tags of the sample
//   out_valid           result valid (2 cycles after in_valid)
//   mag                 unsigned re^2 + im^2
//   out_bin, out_band   tags aligned with mag
module band_magnitude_sq
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BIN_W      = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [DATA_WIDTH-1:0]  re,
    input  logic signed [DATA_WIDTH-1:0]  im,
    input  logic [BIN_W-1:0]              in_bin,
    input  logic [BAND_W-1:0]             in_band,
    output logic                          out_valid,
    output logic [2*DATA_WIDTH-1:0]       mag,
    output logic [BIN_W-1:0]              out_bin,
    output logic [BAND_W-1:0]             out_band
);

    localparam int MAG_W = 2 * DATA_WIDTH;

    logic [2:1]              vld_pipe;
    logic signed [MAG_W-1:0] re_ext, im_ext;
    logic signed [MAG_W-1:0] re_sq, im_sq;
    logic [BIN_W-1:0]        bin_s1;
    logic [BAND_W-1:0]       band_s1;

    assign re_ext    = MAG_W'(re);
    assign im_ext    = MAG_W'(im);
    assign out_valid = vld_pipe[2];

    // Each square is at most 2^30, so the sum (at most 2^31) fits unsigned.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            re_sq    <= '0;
            im_sq    <= '0;
            bin_s1   <= '0;
            band_s1  <= '0;
            mag      <= '0;
            out_bin  <= '0;
            out_band <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], in_valid};
            re_sq    <= re_ext * re_ext;
            im_sq    <= im_ext * im_ext;
            bin_s1   <= in_bin;
            band_s1  <= in_band;
            mag      <= $unsigned(re_sq) + $unsigned(im_sq);
            out_bin  <= bin_s1;
            out_band <= band_s1;
        end
    end

endmodule

// File: rtl/fft_band_peak_extractor.sv
// fft_band_peak_extractor
// After the FFT frame completes, reads bins 0..FFT_LENGTH/2-1 over the DMA
// port, keeps the strongest bin of each band and streams one peak record
// per band.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   fft_done                  level, FFT frame ready
//   dma_active, dma_address   DMA read request (natural bin order)
//   dma_real, dma_imag        signed bin data, READ_LAT after the address
//   peak_valid/peak_ready     record handshake
//   peak_band/bin/mag         record: band, strongest bin, re^2+im^2
//   frame_done                one-cycle pulse after the last record
module fft_band_peak_extractor
    import fft_pkg::*;
#(
    parameter int FFT_LENGTH = 1024,
    parameter int FFT_N      = 10,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_BANDS  = 6,
    parameter int READ_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fft_done,
    output logic                          dma_active,
    output logic [FFT_N-1:0]              dma_address,
    input  logic signed [DATA_WIDTH-1:0]  dma_real,
    input  logic signed [DATA_WIDTH-1:0]  dma_imag,
    output logic                          peak_valid,
    input  logic                          peak_ready,
    output logic [BAND_W-1:0]             peak_band,
    output logic [FFT_N-2:0]              peak_bin,
    output logic [2*DATA_WIDTH-1:0]       peak_mag,
    output logic                          frame_done
);

    localparam int BIN_W     = FFT_N - 1;
    localparam int MAG_W     = 2 * DATA_WIDTH;
    localparam int DRAIN_CYC = READ_LAT + 3;
    localparam int DC_W      = $clog2(DRAIN_CYC + 1);
    localparam logic [FFT_N-1:0]  LAST_ADDR = FFT_N'(FFT_LENGTH / 2 - 1);
    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);

    peak_state_t        state;
    logic [DC_W-1:0]    drain_cnt;
    logic [BAND_W-1:0]  emit_idx;
    logic [BAND_W-1:0]  next_idx;
    logic               scan_start;

    logic [NUM_BANDS-1:0][MAG_W-1:0] band_max;
    logic [NUM_BANDS-1:0][BIN_W-1:0] band_bin;

    // Address tags delayed to line up with the DMA read data.
    logic [READ_LAT:1]            tag_vld;
    logic [READ_LAT:1][BIN_W-1:0] tag_bin;
    logic [BAND_W-1:0]            tag_band;

    logic               m_vld;
    logic [MAG_W-1:0]   m_mag;
    logic [BIN_W-1:0]   m_bin;
    logic [BAND_W-1:0]  m_band;

    assign scan_start = (state == ST_IDLE) && fft_done;
    assign next_idx   = emit_idx + 1'b1;
    assign tag_band   = band_of(int'(tag_bin[READ_LAT]), NUM_BANDS);

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            tag_bin <= '0;
        end else begin
            tag_vld[1] <= dma_active;
            tag_bin[1] <= dma_address[BIN_W-1:0];
            for (int i = 2; i <= READ_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_bin[i] <= tag_bin[i-1];
            end
        end
    end

    band_magnitude_sq #(
        .DATA_WIDTH (DATA_WIDTH),
        .BIN_W      (BIN_W)
    ) u_mag (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (tag_vld[READ_LAT]),
        .re        (dma_real),
        .im        (dma_imag),
        .in_bin    (tag_bin[READ_LAT]),
        .in_band   (tag_band),
        .out_valid (m_vld),
        .mag       (m_mag),
        .out_bin   (m_bin),
        .out_band  (m_band)
    );

    // Strict '>' keeps the earliest (lowest) bin on ties; an untouched band
    // keeps its start bin with magnitude 0.
    always_ff @(posedge clk) begin
        if (rst || scan_start) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                band_max[b] <= '0;
                band_bin[b] <= BIN_W'(band_start(b));
            end
        end else if (m_vld) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                if (m_band == BAND_W'(b) && m_mag > band_max[b]) begin
                    band_max[b] <= m_mag;
                    band_bin[b] <= m_bin;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            dma_active  <= 1'b0;
            dma_address <= '0;
            drain_cnt   <= '0;
            emit_idx    <= '0;
            peak_valid  <= 1'b0;
            peak_band   <= '0;
            peak_bin    <= '0;
            peak_mag    <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (fft_done) begin
                        state       <= ST_SCAN;
                        dma_active  <= 1'b1;
                        dma_address <= '0;
                    end
                end
                ST_SCAN: begin
                    if (dma_address == LAST_ADDR) begin
                        state       <= ST_DRAIN;
                        dma_active  <= 1'b0;
                        dma_address <= '0;
                        drain_cnt   <= '0;
                    end else begin
                        dma_address <= dma_address + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Covers read latency, two magnitude stages and the band update.
                    if (drain_cnt == DC_W'(DRAIN_CYC - 1)) begin
                        state    <= ST_EMIT;
                        emit_idx <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (!peak_valid) begin
                        peak_valid <= 1'b1;
                        peak_band  <= emit_idx;
                        peak_bin   <= band_bin[emit_idx];
                        peak_mag   <= band_max[emit_idx];
                    end else if (peak_ready) begin
                        if (emit_idx == LAST_BAND) begin
                            peak_valid <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= ST_REARM;
                        end else begin
                            emit_idx  <= next_idx;
                            peak_band <= next_idx;
                            peak_bin  <= band_bin[next_idx];
                            peak_mag  <= band_max[next_idx];
                        end
                    end
                end
                ST_REARM: begin
                    // Same frame stays flagged until the FFT drops fft_done.
                    if (!fft_done)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_band_peak_extractor.sv
module tb_fft_band_peak_extractor;
    import fft_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               fft_done = 1'b0;
    logic               peak_ready = 1'b0;
    logic               dma_active;
    logic [9:0]         dma_address;
    logic signed [15:0] dma_real = '0;
    logic signed [15:0] dma_imag = '0;
    logic               peak_valid;
    logic [2:0]         peak_band;
    logic [8:0]         peak_bin;
    logic [31:0]        peak_mag;
    logic               frame_done;

    fft_band_peak_extractor dut (
        .clk         (clk),
        .rst         (rst),
        .fft_done    (fft_done),
        .dma_active  (dma_active),
        .dma_address (dma_address),
        .dma_real    (dma_real),
        .dma_imag    (dma_imag),
        .peak_valid  (peak_valid),
        .peak_ready  (peak_ready),
        .peak_band   (peak_band),
        .peak_bin    (peak_bin),
        .peak_mag    (peak_mag),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // FFT DMA model: one cycle read latency.
    logic signed [15:0] re_mem [512];
    logic signed [15:0] im_mem [512];

    always @(posedge clk) begin
        if (dma_active) begin
            dma_real <= re_mem[dma_address[8:0]];
            dma_imag <= im_mem[dma_address[8:0]];
        end else begin
            dma_real <= '0;
            dma_imag <= '0;
        end
    end

    int act_cyc  = 0;
    int fd_cnt   = 0;
    int max_addr = 0;

    always @(negedge clk) begin
        if (dma_active) begin
            act_cyc++;
            if (int'(dma_address) > max_addr)
                max_addr = int'(dma_address);
        end
        if (frame_done)
            fd_cnt++;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          exp_bin [6];
    logic [31:0] exp_mag [6];

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) begin
            re_mem[i] = '0;
            im_mem[i] = '0;
        end
    endtask

    task automatic load_tone();
        clear_mem();
        re_mem[50] = 16'sd1000;
        exp_bin = '{0, 10, 20, 50, 80, 160};
        exp_mag = '{32'd0, 32'd0, 32'd0, 32'd1000000, 32'd0, 32'd0};
    endtask

    // Runs one frame from a negedge with the DUT idle (or in reset about to release).
    task automatic run_frame(input int drop_at, input int stall_band);
        int          n;
        bit          got;
        bit          stable;
        int          act_base;
        int          fd_base;
        logic [2:0]  sb;
        logic [8:0]  sbin;
        logic [31:0] smag;
        act_base   = act_cyc;
        fd_base    = fd_cnt;
        peak_ready = 1'b1;
        fft_done   = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("scan_active", dma_active, 1);
                chk("scan_addr0", dma_address, 0);
            end
            if (n == drop_at)
                fft_done = 1'b0;
            if (peak_valid)
                got = 1'b1;
        end
        chk("first_valid_lat", n - 1, 517);
        if (!got)
            return;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rec%0d_valid", i), peak_valid, 1);
            chk($sformatf("rec%0d_band", i), peak_band, i);
            chk($sformatf("rec%0d_bin", i), peak_bin, exp_bin[i]);
            chk($sformatf("rec%0d_mag", i), peak_mag, exp_mag[i]);
            if (i == stall_band) begin
                peak_ready = 1'b0;
                sb     = peak_band;
                sbin   = peak_bin;
                smag   = peak_mag;
                stable = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    if (!peak_valid || peak_band !== sb || peak_bin !== sbin || peak_mag !== smag)
                        stable = 1'b0;
                end
                chk("stall_stable", stable, 1);
                peak_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("frame_done_pulse", frame_done, 1);
        chk("valid_after_last", peak_valid, 0);
        @(negedge clk);
        chk("frame_done_low", frame_done, 0);
        chk("frame_done_count", fd_cnt - fd_base, 1);
        chk("scan_cycles", act_cyc - act_base, 512);
    endtask

    initial begin
        int  base;
        bit  hit;
        clear_mem();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dma_active", dma_active, 0);
        chk("rst_dma_address", dma_address, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_peak_mag", peak_mag, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b0;

        // Single tone in band 3; other bands report their start bin
        load_tone();
        run_frame(0, -1);

        // fft_done still high after the frame: no rescan
        base = act_cyc;
        repeat (30) @(negedge clk);
        chk("rearm_no_rescan", act_cyc - base, 0);
        fft_done = 1'b0;
        repeat (2) @(negedge clk);

        // Ties, full-scale bin, stall on band 2, fft_done dropped mid-scan
        clear_mem();
        re_mem[12]  = 16'sd20;
        im_mem[17]  = -16'sd20;
        re_mem[25]  = 16'sd3;
        im_mem[25]  = 16'sd4;
        re_mem[30]  = -16'sd5;
        re_mem[300] = -16'sd32768;
        im_mem[300] = -16'sd32768;
        exp_bin = '{0, 12, 25, 40, 80, 300};
        exp_mag = '{32'd0, 32'd400, 32'd25, 32'd0, 32'd0, 32'h8000_0000};
        run_frame(100, 2);
        repeat (2) @(negedge clk);

        // Reset mid-scan at address 200, then full rescan with fft_done held
        load_tone();
        fft_done = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(negedge clk);
            if (dma_active && dma_address == 10'd200)
                hit = 1'b1;
        end
        chk("reached_addr200", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_peak_valid", peak_valid, 0);
        chk("midrst_dma_active", dma_active, 0);
        chk("midrst_dma_address", dma_address, 0);
        chk("midrst_state_idle", dut.state, ST_IDLE);
        rst = 1'b0;
        run_frame(0, -1);

        chk("max_dma_address", max_addr, 511);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
